// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-Stream frame FIFO: frames become visible only once their
// last beat is stored, and frames that do not fit are dropped and counted.
module axis_frame_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [ADDR_WIDTH:0]   frame_cnt,
    output logic                  drop_pulse,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]  PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]  FULL_DIFF = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        WRITE,
        DROP
    } state_t;

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [DATA_WIDTH:0] rd_entry;
    logic [ADDR_WIDTH:0] wr_ptr, wr_commit, rd_ptr;
    logic                full, accept, read, last_read;
    logic                write_beat, commit, rewind;
    state_t              state, state_next;

    // Ready follows reset directly: the FIFO never back-pressures, it drops instead.
    assign s_tready  = rst_n;
    assign accept    = s_tvalid && s_tready;
    assign full      = (wr_ptr - rd_ptr) == FULL_DIFF;

    assign rd_entry  = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign m_tvalid  = rst_n && (rd_ptr != wr_commit);
    assign m_tdata   = rd_entry[DATA_WIDTH-1:0];
    assign m_tlast   = rst_n && rd_entry[DATA_WIDTH];
    assign read      = m_tvalid && m_tready;
    assign last_read = read && m_tlast;

    always_comb begin
        state_next = state;
        write_beat = 1'b0;
        commit     = 1'b0;
        rewind     = 1'b0;
        drop_pulse = 1'b0;
        case (state)
            WRITE: begin
                if (accept) begin
                    if (!full) begin
                        write_beat = 1'b1;
                        commit     = s_tlast;
                    end else begin
                        // Rewinding to the last commit point discards the partial frame.
                        rewind = 1'b1;
                        if (s_tlast) begin
                            drop_pulse = 1'b1;
                        end else begin
                            state_next = DROP;
                        end
                    end
                end
            end
            DROP: begin
                if (accept && s_tlast) begin
                    drop_pulse = 1'b1;
                    state_next = WRITE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WRITE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            state <= state_next;
            if (write_beat) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end else if (rewind) begin
                wr_ptr <= wr_commit;
            end
            if (commit) begin
                wr_commit <= wr_ptr + PTR_ONE;
            end
            if (read) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (commit && !last_read) begin
                frame_cnt <= frame_cnt + PTR_ONE;
            end else if (!commit && last_read) begin
                frame_cnt <= frame_cnt - PTR_ONE;
            end
            if (drop_pulse && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_ONE;
            end
        end
    end

    // Storage carries no reset; visibility is governed entirely by the pointers.
    always_ff @(posedge clk) begin
        if (write_beat) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_tlast, s_tdata};
        end
    end

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Bench for axis_frame_fifo: directed frame scenarios plus random traffic, all
// checked every cycle against a queue-based model of committed and open frames.
module tb_axis_frame_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int CW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic [AW:0]   frame_cnt;
    logic          drop_pulse;
    logic [CW-1:0] drop_cnt;

    int checks = 0;
    int failures = 0;

    typedef logic [DW:0] beat_t;
    beat_t stored_q[$];
    beat_t open_q[$];
    bit    dropping = 1'b0;
    int    drops = 0;

    axis_frame_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .frame_cnt(frame_cnt), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic int model_frames();
        int n = 0;
        foreach (stored_q[i]) if (stored_q[i][DW]) n++;
        return n;
    endfunction

    // Drive one cycle, compare every output with the model, then advance the model.
    task automatic applyStimulus(input logic v, input logic l, input logic [DW-1:0] d, input logic r);
        bit full;
        bit exp_drop;
        @(negedge clk);
        s_tvalid = v;
        s_tlast  = l;
        s_tdata  = d;
        m_tready = r;
        #1;
        full     = (stored_q.size() + open_q.size()) >= DEPTH;
        exp_drop = 1'b0;
        checkOutput("s_tready", 32'(s_tready), 32'd1);
        checkOutput("m_tvalid", 32'(m_tvalid), 32'(stored_q.size() != 0));
        if (stored_q.size() != 0) begin
            checkOutput("m_tdata", 32'(m_tdata), 32'(stored_q[0][DW-1:0]));
            checkOutput("m_tlast", 32'(m_tlast), 32'(stored_q[0][DW]));
        end
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(model_frames()));
        checkOutput("drop_cnt", 32'(drop_cnt), 32'(drops));
        if (stored_q.size() != 0 && r) void'(stored_q.pop_front());
        if (v) begin
            if (dropping) begin
                if (l) begin
                    exp_drop = 1'b1;
                    dropping = 1'b0;
                end
            end else if (full) begin
                open_q.delete();
                if (l) exp_drop = 1'b1;
                else dropping = 1'b1;
            end else begin
                open_q.push_back({l, d});
                if (l) begin
                    foreach (open_q[i]) stored_q.push_back(open_q[i]);
                    open_q.delete();
                end
            end
        end
        if (exp_drop && drops < 65535) drops++;
        checkOutput("drop_pulse", 32'(drop_pulse), 32'(exp_drop));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n    = 1'b0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        m_tready = 1'b1;
        #1;
        checkOutput("rst_s_tready", 32'(s_tready), 32'd0);
        checkOutput("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("rst_m_tlast", 32'(m_tlast), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        checkOutput("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        stored_q.delete();
        open_q.delete();
        dropping = 1'b0;
        drops = 0;
        @(negedge clk);
        rst_n    = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
        checkOutput("release_s_tready", 32'(s_tready), 32'd1);
    endtask

    task automatic sendFrame(input int n, input logic [DW-1:0] base, input logic r);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, i == n - 1, base + DW'(i), r);
    endtask

    task automatic idleCycles(input int n, input logic r);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, DW'($urandom), r);
    endtask

    initial begin
        doReset();

        // Three-beat frame streams straight through once committed.
        sendFrame(3, 8'hA1, 1'b1);
        idleCycles(5, 1'b1);

        // 17-beat frame cannot fit; a 16-beat frame then fills the buffer exactly.
        sendFrame(17, 8'h00, 1'b0);
        idleCycles(1, 1'b0);
        checkOutput("oversize_drop_cnt", 32'(drop_cnt), 32'd1);
        checkOutput("oversize_m_tvalid", 32'(m_tvalid), 32'd0);
        sendFrame(16, 8'h40, 1'b0);
        idleCycles(1, 1'b0);
        checkOutput("exact_fit_frame_cnt", 32'(frame_cnt), 32'd1);
        idleCycles(20, 1'b1);

        // Second 10-beat frame overflows mid-frame and is dropped via DROP.
        doReset();
        sendFrame(10, 8'h10, 1'b0);
        sendFrame(10, 8'h20, 1'b0);
        idleCycles(1, 1'b0);
        checkOutput("overflow_drop_cnt", 32'(drop_cnt), 32'd1);
        idleCycles(12, 1'b1);
        sendFrame(3, 8'h30, 1'b1);
        idleCycles(5, 1'b1);

        // Commit of frame B lands on the edge that reads frame A's last beat.
        sendFrame(3, 8'h60, 1'b0);
        sendFrame(3, 8'h70, 1'b1);
        idleCycles(1, 1'b0);
        checkOutput("same_edge_frame_cnt", 32'(frame_cnt), 32'd1);
        checkOutput("same_edge_next_data", 32'(m_tdata), 32'h70);
        idleCycles(5, 1'b1);

        // Reset in the middle of an open frame.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'h80 + 8'(i), 1'b1);
        doReset();
        sendFrame(2, 8'h50, 1'b1);
        idleCycles(4, 1'b1);
        checkOutput("mid_reset_drop_cnt", 32'(drop_cnt), 32'd0);

        // Random traffic with progressively weaker downstream readiness.
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 500; i++) begin
                applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0,
                              DW'($urandom), $urandom_range(0, 9) < (9 - 3 * phase));
            end
        end
        idleCycles(40, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_frame_fifo.md
AXIS_FRAME_FIFO -- requirements
Module: axis_frame_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning tdata width in bits on both ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning buffer depth DEPTH = 2**ADDR_WIDTH beats.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning width of the dropped-frame counter.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 s_tdata  input  DATA_WIDTH  slave beat data.
REQ-008 s_tvalid  input  1  slave beat valid.
REQ-009 s_tready  output  1  slave ready.
REQ-010 s_tlast  input  1  last beat of the slave frame.
REQ-011 m_tdata  output  DATA_WIDTH  master beat data.
REQ-012 m_tvalid  output  1  master beat valid.
REQ-013 m_tready  input  1  master ready.
REQ-014 m_tlast  output  1  last beat of the master frame.
REQ-015 frame_cnt  output  ADDR_WIDTH+1  committed frames not yet fully read.
REQ-016 drop_pulse  output  1  one-cycle pulse per dropped frame.
REQ-017 drop_cnt  output  CNT_WIDTH  saturating count of dropped frames.

Function
REQ-018 SHALL be store-and-forward: no beat of a frame is presented on the master side until its s_tlast beat is accepted.
REQ-019 SHALL store {tlast, tdata} per entry in a DEPTH-entry memory, with wr_ptr, wr_commit and rd_ptr each ADDR_WIDTH+1 bits wide and wrapping modulo 2*DEPTH.
REQ-020 SHALL compute full as (wr_ptr - rd_ptr) == DEPTH, using pointer values before the current edge; a same-cycle read does not relieve full.
REQ-021 SHALL hold s_tready = 1 in every cycle after reset release; frames are never back-pressured, only dropped.
REQ-022 SHALL accept a slave beat when s_tvalid && s_tready.
REQ-023 SHALL implement a two-state FSM, WRITE (reset state) and DROP.
REQ-024 In WRITE, on an accepted beat with !full, SHALL write the entry at wr_ptr and increment wr_ptr; if s_tlast is set, wr_commit <= wr_ptr+1 on the same edge.
REQ-025 In WRITE, on an accepted beat with full, SHALL discard the beat and set wr_ptr <= wr_commit. If s_tlast is set, it SHALL pulse drop_pulse and stay in WRITE; otherwise it SHALL go to DROP.
REQ-026 In DROP, SHALL discard every accepted beat; on the s_tlast beat it SHALL pulse drop_pulse and return to WRITE.
REQ-027 Frames longer than DEPTH beats SHALL always be dropped; a frame of exactly DEPTH beats into an empty buffer SHALL be committed.
REQ-028 SHALL drive m_tvalid = (rd_ptr != wr_commit) and m_tdata/m_tlast = mem[rd_ptr] combinationally, so a frame's first beat is valid in the cycle after its tlast is accepted.
REQ-029 SHALL increment rd_ptr on m_tvalid && m_tready; m_tdata and m_tlast SHALL be held stable while m_tvalid && !m_tready.
REQ-030 SHALL update frame_cnt by +1 on commit and -1 on an m_tlast handshake, leaving it unchanged when both occur on the same edge.
REQ-031 SHALL increment drop_cnt on each drop_pulse and saturate at all-ones.
REQ-032 SHALL never let uncommitted entries (wr_commit..wr_ptr) become visible on the master side.

Reset
REQ-033 On rst_n low, SHALL immediately clear wr_ptr, wr_commit, rd_ptr, frame_cnt and drop_cnt, and set the FSM to WRITE.
REQ-034 On rst_n low, SHALL immediately drive s_tready=0, m_tvalid=0, m_tlast=0 and drop_pulse=0; memory contents are not reset.
REQ-035 On reset mid-frame, SHALL discard the partial and stored frames; a following beat without tlast starts a new frame.

Verification (DEPTH=16)
REQ-036 Reset asserted -> s_tready=0, m_tvalid=0, frame_cnt=0, drop_cnt=0; first cycle after release -> s_tready=1.
REQ-037 Frame 0xA1,0xA2,0xA3 with m_tready=1 -> m_tvalid stays 0 until the cycle after 0xA3 is accepted; then 0xA1,0xA2,0xA3 on consecutive cycles, m_tlast only on 0xA3; frame_cnt 0->1->0.
REQ-038 m_tready=0, 17-beat frame -> 17th beat dropped, drop_pulse once on its tlast, drop_cnt=1, m_tvalid stays 0; then a 16-beat frame is committed and frame_cnt=1.
REQ-039 m_tready=0, 10-beat frame then 10-beat frame -> first committed, second dropped at its 7th beat via DROP state, drop_cnt=1; draining yields exactly 10 beats, then a 3-beat frame is committed normally.
REQ-040 Commit of frame B on the same edge as the m_tlast handshake of frame A -> frame_cnt unchanged, B output next.
REQ-041 Reset pulse after 5 beats of an open frame -> no output; a following 2-beat frame is output intact and drop_cnt=0.
